uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- Parallel-to-serial UART transmitter. It is the transmit end of the link whose receiver samples at 16x oversampling.
- Bytes are queued into a small internal FIFO and serialised LSB-first as 8N1 frames on `tx`.
- Timing comes from the same 16x tick used on the receive side, so each bit is held for exactly 16 ticks.
- Sits between the CPU/bus write path and the pad.

Parameters:
- FIFO_DEPTH, 4, number of queued bytes; must be a power of 2, minimum 2.
- OVS, 16, tx_enb ticks per serial bit; must match the receiver oversampling.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- tx_enb  input  1  16x baud tick, one clk wide; all serial timing advances only on cycles where it is 1
- wr_en  input  1  write strobe; data_in is pushed to the FIFO if not full
- data_in  input  8  byte to transmit
- tx  output  1  serial line, idle high
- tx_busy  output  1  1 while the FIFO is non-empty or a frame is in flight
- tx_full  output  1  FIFO full; writes are ignored
- ovf  output  1  sticky overflow flag: a write was dropped
- ovf_clr  input  1  clears ovf

Behaviour:
- Reset (rst=0, asynchronous):
  - tx=1, tx_busy=0, tx_full=0, ovf=0.
  - State=IDLE; FIFO pointers, count, sample counter and bit index all 0.
  - Reset mid-frame aborts the frame; the line returns high immediately.
- FIFO:
  - Push on wr_en && !tx_full, independent of tx_enb.
  - Count width is clog2(FIFO_DEPTH)+1. tx_full = (count==FIFO_DEPTH), registered.
  - wr_en while tx_full drops the byte and sets ovf, even if a pop occurs in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop in a non-full FIFO leaves count unchanged.
- ovf: set by a dropped write; cleared by ovf_clr. If both happen in the same cycle, set wins.
- Line output: tx is registered and driven from state.
  - IDLE=1, START=0, DATA=shift[index], STOP=1.
- State machine: states IDLE, START, DATA, STOP.
  - sample increments only on tx_enb; at sample==OVS-1 with tx_enb it resets to 0 and the state advances.
  - IDLE: on tx_enb with FIFO non-empty, pop the head into the shift register and go to START, with sample=0 and index=0. tx falls on the next clk.
  - START: after OVS ticks, go to DATA.
  - DATA: after each OVS ticks, index++. At index==7 go to STOP. Bits are sent LSB first.
  - STOP: after OVS ticks:
    - if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no extra idle bit);
    - otherwise go to IDLE.
- Timing: one frame = 10*OVS tx_enb ticks = 160 with defaults. The start bit begins within 1 tick of data being available while IDLE.
- tx_enb=0: state, sample and tx are frozen; FIFO writes still accepted.
- tx_busy = (state!=IDLE) || (count!=0), registered. It drops in the cycle after the final stop bit completes with an empty FIFO.
- Undefined state encodings recover to IDLE with tx=1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting OVS ticks.
  - tx = XOR of the 8 data bits (even parity).
  - Frame length becomes 11*OVS ticks.
  - The peer receiver must be built with the matching option.
- Undefined:
  - No PARITY state; frames are 8N1 as described above. Logic is absent, not merely disabled.

Test Plan:
- Reset then write 8'hA5, tx_enb every 4 clk -> tx low for 16 ticks, then bits 1,0,1,0,0,1,0,1 for 16 ticks each, then high for 16 ticks. tx_busy=1 throughout and 0 one clk after the stop bit completes.
- Write 8'h00, 8'hFF, 8'h3C back-to-back -> three contiguous frames totalling 480 ticks with no idle gap between stop and start. The bench's 16x receiver model decodes 00, FF, 3C.
- With tx_enb held 0, write 5 bytes at FIFO_DEPTH=4 -> tx_full=1 after the 4th write, 5th byte dropped, ovf=1. ovf_clr pulse -> ovf=0. Enabling ticks transmits exactly the first 4 bytes.
- Assert rst mid-DATA of 8'h5A -> tx=1 asynchronously, tx_busy=0, FIFO empty. A new write of 8'h81 then produces a clean frame.
- Pause tx_enb for 100 clk in the middle of bit 3 -> tx and the bit position are held, and the frame resumes with correct remaining durations.
- With UART_TX_PARITY_EN, send 8'h07 -> parity bit 1. Send 8'h03 -> parity bit 0. Frame length is 176 ticks.

Source files
------------

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//
// Purpose:
//   Parallel-to-serial UART transmitter. Bytes are queued in a small FIFO and
//   serialised LSB-first as 8N1 frames. The serial timing follows the same
//   oversampled tick as the matching receiver, so every bit lasts OVS ticks.
//
// Build option:
//   UART_TX_PARITY_EN - when defined, an even-parity bit is sent between the
//                       last data bit and the stop bit (11*OVS ticks per
//                       frame). When undefined, the parity logic is not built.
//
// Parameters:
//   FIFO_DEPTH - queued bytes (power of 2, >= 2)
//   OVS        - tx_enb ticks per serial bit
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   tx_enb   in   oversampling tick, one clk wide
//   wr_en    in   write strobe, pushes data_in when not full
//   data_in  in   byte to transmit
//   ovf_clr  in   clears the sticky overflow flag
//   tx       out  serial line, idle high
//   tx_busy  out  FIFO non-empty or frame in flight
//   tx_full  out  FIFO full, writes are dropped
//   ovf      out  sticky flag: a write was dropped
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | line high, waiting for a tick with data queued
// START  | start bit (low) for OVS ticks
// DATA   | data bit shift_q[index_q] for OVS ticks each
// PARITY | even parity of the byte (parity builds only)
// STOP   | stop bit (high), then next frame or IDLE
// -----------------------------------------------------------------------------
module uart_transmitter #(
  parameter int FIFO_DEPTH = 4,
  parameter int OVS        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_enb,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  input  logic       ovf_clr,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_full,
  output logic       ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SMP_W = (OVS > 1) ? $clog2(OVS) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVS - 1);

`ifdef UART_TX_PARITY_EN
  localparam int ST_W = 3;
`else
  localparam int ST_W = 2;
`endif

  localparam logic [ST_W-1:0] ST_IDLE   = ST_W'(0);
  localparam logic [ST_W-1:0] ST_START  = ST_W'(1);
  localparam logic [ST_W-1:0] ST_DATA   = ST_W'(2);
  localparam logic [ST_W-1:0] ST_STOP   = ST_W'(3);
`ifdef UART_TX_PARITY_EN
  localparam logic [ST_W-1:0] ST_PARITY = ST_W'(4);
`endif

  // FIFO storage and bookkeeping
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q;
  logic             ovf_q, ovf_d;
  logic             busy_q;

  // Serialiser
  logic [ST_W-1:0]  state_q, state_d;
  logic [SMP_W-1:0] sample_q, sample_d;
  logic [2:0]       index_q, index_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  logic push, pop, drop, last_tick, fifo_nempty;

  assign push        = wr_en && !full_q;
  assign drop        = wr_en && full_q;
  assign fifo_nempty = (count_q != '0);
  assign last_tick   = tx_enb && (sample_q == SMP_LAST);

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    index_d  = index_q;
    shift_d  = shift_q;
    pop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_enb && fifo_nempty) begin
          pop      = 1'b1;
          shift_d  = mem_q[rd_ptr_q];
          state_d  = ST_START;
          sample_d = '0;
          index_d  = '0;
        end
      end

      ST_START: begin
        if (last_tick) begin
          sample_d = '0;
          state_d  = ST_DATA;
        end else if (tx_enb) begin
          sample_d = sample_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (last_tick) begin
          sample_d = '0;
          if (index_q == 3'd7) begin
            index_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            index_d = index_q + 3'd1;
          end
        end else if (tx_enb) begin
          sample_d = sample_q + 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (last_tick) begin
          sample_d = '0;
          state_d  = ST_STOP;
        end else if (tx_enb) begin
          sample_d = sample_q + 1'b1;
        end
      end
`endif

      ST_STOP: begin
        if (last_tick) begin
          sample_d = '0;
          index_d  = '0;
          // Chain straight into the next start bit so queued bytes go out
          // without an idle bit between frames.
          if (fifo_nempty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tx_enb) begin
          sample_d = sample_q + 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        sample_d = '0;
        index_d  = '0;
      end
    endcase
  end

  // tx is registered from the next state so the line changes on the same
  // edge as the state, e.g. the start bit falls on the clk after the pop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[index_d];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = ^shift_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  // Set has priority over clear so a drop in the clearing cycle is not lost.
  assign ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      state_q  <= ST_IDLE;
      sample_q <= '0;
      index_q  <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_FULL);
      ovf_q    <= ovf_d;
      busy_q   <= (state_d != ST_IDLE) || (count_d != '0);
      state_q  <= state_d;
      sample_q <= sample_d;
      index_q  <= index_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_full = full_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;

  localparam int FIFO_DEPTH = 4;
  localparam int OVS        = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * OVS;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_enb = 1'b0;
  logic       wr_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx, tx_busy, tx_full, ovf;

  int vectors = 0;
  int miscompares = 0;

  bit tick_run = 1'b1;
  int tick_div = 4;

  logic       ticks[$];   // line value seen during each tick
  logic [7:0] exp_q[$];   // bytes expected on the line, in order

  uart_transmitter #(.FIFO_DEPTH(FIFO_DEPTH), .OVS(OVS)) dut (
    .clk(clk), .rst(rst), .tx_enb(tx_enb), .wr_en(wr_en), .data_in(data_in),
    .ovf_clr(ovf_clr), .tx(tx), .tx_busy(tx_busy), .tx_full(tx_full), .ovf(ovf)
  );

  initial forever #5 clk = ~clk;

  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!tick_run) begin
        tx_enb = 1'b0;
        div = 0;
      end else begin
        tx_enb = (div == 0);
        div = (div + 1 >= tick_div) ? 0 : div + 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (tx_enb === 1'b1) ticks.push_back(tx);
  end

  // Reference frame: start 0, 8 data bits LSB first, optional even parity, stop 1.
  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
`ifdef UART_TX_PARITY_EN
    if (pos == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic int first_zero();
    for (int i = 0; i < ticks.size(); i++) if (ticks[i] !== 1'b1) return i;
    return -1;
  endfunction

  task automatic clear_log();
    @(posedge clk);
    #2;
    ticks.delete();
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    wr_en = 1'b1;
    data_in = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int budget;
    bit done;
    budget = (FIFO_DEPTH + 2) * FRAME * tick_div + 200;
    done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!tx_busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s idle_timeout: tx_busy still %b after %0d clk, want 0", name, tx_busy, budget);
    end
    repeat (2 * OVS * tick_div + 4) @(negedge clk);
  endtask

  task automatic wait_frame_pos(input string name, input int off);
    int s;
    bit done;
    done = 1'b0;
    for (int c = 0; c < 4 * FRAME * tick_div + 200; c++) begin
      @(negedge clk);
      s = first_zero();
      if (s >= 0 && ticks.size() > s + off) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s pos_timeout: got %0d ticks logged, want start+%0d", name, ticks.size(), off);
    end
  endtask

  task automatic check_stream(input string name, input bit contiguous);
    int p, gap, first_start, bad, zeros;
    logic [7:0] got;
    p = 0;
    first_start = 0;
    for (int f = 0; f < exp_q.size(); f++) begin
      gap = 0;
      while (p < ticks.size() && ticks[p] === 1'b1) begin
        p++;
        gap++;
      end
      if (f == 0) first_start = p;
      if (f > 0 && contiguous) begin
        vectors++;
        if (gap != 0) begin
          miscompares++;
          $display("FAIL %s gap frame %0d: got %0d idle ticks, want 0", name, f, gap);
        end
      end
      if (p + FRAME > ticks.size()) begin
        vectors++;
        miscompares++;
        $display("FAIL %s frame %0d truncated: got %0d ticks, want %0d", name, f, ticks.size() - p, FRAME);
        return;
      end
      bad = -1;
      for (int k = 0; k < FRAME; k++) begin
        if (ticks[p+k] !== frame_bit(exp_q[f], k / OVS)) begin
          bad = k;
          break;
        end
      end
      vectors++;
      if (bad >= 0) begin
        miscompares++;
        $display("FAIL %s wave frame %0d tick %0d: got %b, want %b", name, f, bad,
                 ticks[p+bad], frame_bit(exp_q[f], bad / OVS));
      end
      // 16x receiver model: sample each data bit at its centre
      got = 8'h00;
      for (int i = 0; i < 8; i++) got[i] = ticks[p + (i + 1) * OVS + OVS / 2];
      vectors++;
      if (got !== exp_q[f]) begin
        miscompares++;
        $display("FAIL %s decode frame %0d: got %h, want %h", name, f, got, exp_q[f]);
      end
      p += FRAME;
    end
    if (contiguous) begin
      vectors++;
      if (p - first_start != exp_q.size() * FRAME) begin
        miscompares++;
        $display("FAIL %s total_ticks: got %0d, want %0d", name, p - first_start, exp_q.size() * FRAME);
      end
    end
    zeros = 0;
    for (int k = p; k < ticks.size(); k++) if (ticks[k] !== 1'b1) zeros++;
    vectors++;
    if (zeros != 0) begin
      miscompares++;
      $display("FAIL %s trailing: got %0d low ticks after last frame, want 0", name, zeros);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick_run = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b, want 1", tx); end
    vectors++;
    if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, want 0", tx_busy); end
    vectors++;
    if (tx_full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b, want 0", tx_full); end
    vectors++;
    if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b, want 0", ovf); end
    rst = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got tx=%b busy=%b, want tx=1 busy=0", tx, tx_busy);
    end
  endtask

  task automatic test_single();
    int n;
    bit prev, done;
    tick_div = 4;
    clear_log();
    exp_q.delete();
    exp_q.push_back(8'hA5);
    @(negedge clk);
    wr_en = 1'b1;
    data_in = 8'hA5;
    @(posedge clk);
    n = 0;
    prev = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 2 * FRAME * tick_div + 100; c++) begin
      @(negedge clk);
      if (c == 0) wr_en = 1'b0;
      if (!tx_busy) begin
        done = 1'b1;
        break;
      end
      prev = tx_enb;
      if (tx_enb) n++;
    end
    vectors++;
    if (!done || n != FRAME + 1 || prev !== 1'b1) begin
      miscompares++;
      $display("FAIL single_busy: got done=%b ticks=%0d last_clk_tick=%b, want done=1 ticks=%0d last_clk_tick=1",
               done, n, prev, FRAME + 1);
    end
    repeat (2 * OVS * tick_div + 4) @(negedge clk);
    check_stream("single", 1'b0);
  endtask

  task automatic test_back_to_back();
    tick_div = 4;
    clear_log();
    exp_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    foreach (exp_q[i]) write_byte(exp_q[i]);
    wait_idle("b2b");
    check_stream("b2b", 1'b1);
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    tick_div = 4;
    tick_run = 1'b0;
    repeat (3) @(negedge clk);
    clear_log();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      if (i < FIFO_DEPTH) exp_q.push_back(b);
      write_byte(b);
      if (i == FIFO_DEPTH - 2) begin
        vectors++;
        if (tx_full !== 1'b0) begin miscompares++; $display("FAIL full_early: got %b, want 0", tx_full); end
      end
      if (i == FIFO_DEPTH - 1) begin
        vectors++;
        if (tx_full !== 1'b1 || ovf !== 1'b0) begin
          miscompares++;
          $display("FAIL full_at_depth: got full=%b ovf=%b, want full=1 ovf=0", tx_full, ovf);
        end
      end
      if (i == FIFO_DEPTH) begin
        vectors++;
        if (ovf !== 1'b1 || tx_full !== 1'b1) begin
          miscompares++;
          $display("FAIL ovf_set: got ovf=%b full=%b, want ovf=1 full=1", ovf, tx_full);
        end
      end
    end
    @(negedge clk);
    wr_en = 1'b1;
    data_in = 8'h99;
    ovf_clr = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    ovf_clr = 1'b0;
    vectors++;
    if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_set_wins: got %b, want 1", ovf); end
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    vectors++;
    if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b, want 0", ovf); end
    tick_run = 1'b1;
    wait_idle("ovf");
    check_stream("ovf", 1'b1);
  endtask

  task automatic test_reset_mid();
    tick_div = 4;
    clear_log();
    exp_q.delete();
    exp_q.push_back(8'h5A);
    write_byte(8'h5A);
    wait_frame_pos("rst_mid", OVS + OVS / 2);   // centre of data bit 0 (a 0 for 5A)
    #2;
    vectors++;
    if (tx !== 1'b0) begin miscompares++; $display("FAIL rst_mid_pre: got tx=%b, want 0", tx); end
    rst = 1'b0;
    #1;
    vectors++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_full !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_async: got tx=%b busy=%b full=%b, want 1 0 0", tx, tx_busy, tx_full);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_empty: got busy=%b, want 0", tx_busy); end
    clear_log();
    exp_q.delete();
    exp_q.push_back(8'h81);
    write_byte(8'h81);
    wait_idle("after_rst");
    check_stream("after_rst", 1'b0);
  endtask

  task automatic test_pause();
    logic [7:0] b;
    logic held_tx;
    int held_n, moved;
    tick_div = 4;
    b = 8'($urandom);
    clear_log();
    exp_q.delete();
    exp_q.push_back(b);
    write_byte(b);
    wait_frame_pos("pause", 4 * OVS + OVS / 2);  // centre of data bit 3
    tick_run = 1'b0;
    repeat (2) @(negedge clk);
    held_tx = tx;
    held_n = ticks.size();
    moved = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== held_tx) moved++;
    end
    vectors++;
    if (held_tx !== b[3]) begin miscompares++; $display("FAIL pause_bit3: got %b, want %b", held_tx, b[3]); end
    vectors++;
    if (moved != 0 || ticks.size() != held_n) begin
      miscompares++;
      $display("FAIL pause_hold: got %0d tx changes, %0d ticks, want 0 and %0d", moved, ticks.size(), held_n);
    end
    tick_run = 1'b1;
    wait_idle("pause");
    check_stream("pause", 1'b0);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int s;
    tick_div = 4;
    clear_log();
    exp_q.delete();
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h03);
    foreach (exp_q[i]) write_byte(exp_q[i]);
    wait_idle("parity");
    check_stream("parity", 1'b1);
    s = first_zero();
    vectors++;
    if (s < 0 || ticks.size() < s + 2 * FRAME) begin
      miscompares++;
      $display("FAIL parity_len: got %0d ticks from start, want %0d", ticks.size() - s, 2 * FRAME);
    end else if (ticks[s + 9 * OVS + OVS / 2] !== 1'b1 || ticks[s + FRAME + 9 * OVS + OVS / 2] !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_bits: got %b %b, want 1 0", ticks[s + 9 * OVS + OVS / 2],
               ticks[s + FRAME + 9 * OVS + OVS / 2]);
    end
  endtask
`endif

  task automatic test_random();
    int n;
    for (int r = 0; r < 4; r++) begin
      tick_div = $urandom_range(1, 4);
      n = $urandom_range(1, FIFO_DEPTH);
      clear_log();
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom));
      foreach (exp_q[i]) begin
        write_byte(exp_q[i]);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle("random");
      check_stream("random", 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_pause();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
